mem_rd_stream: RTL

//  Read-side controller for a mem_dist buffer: on a start pulse, drives the memory read port over a

---
 rtl/mem_rd_pkg.sv | 13 +
 rtl/mem_rd_stream_if.sv | 37 +++
 rtl/mem_rd_skid.sv | 69 ++++++
 rtl/mem_rd_stream.sv | 131 +++++++++++++
 4 files changed

// File: rtl/mem_rd_pkg.sv
// rtl/mem_rd_pkg.sv - shared types and constants for the mem_rd_stream read controller
package mem_rd_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam int SKID_DEPTH = 2;

endpackage

// File: rtl/mem_rd_stream_if.sv
// rtl/mem_rd_stream_if.sv - memory read port and output stream bundle (m_last only with MEM_RD_STREAM_LAST_EN)
interface mem_rd_stream_if #(
    parameter int WIDTH = 32,
    parameter int AW    = 9
);

    logic             rd_en;
    logic [AW-1:0]    rd_addr;
    logic [WIDTH-1:0] rd_data;
    logic             m_valid;
    logic [WIDTH-1:0] m_data;
    logic             m_ready;
`ifdef MEM_RD_STREAM_LAST_EN
    logic             m_last;

    modport master (
        output rd_en, rd_addr, m_valid, m_data, m_last,
        input  rd_data, m_ready
    );

    modport slave (
        input  rd_en, rd_addr, m_valid, m_data, m_last,
        output rd_data, m_ready
    );
`else
    modport master (
        output rd_en, rd_addr, m_valid, m_data,
        input  rd_data, m_ready
    );

    modport slave (
        input  rd_en, rd_addr, m_valid, m_data,
        output rd_data, m_ready
    );
`endif

endinterface

// File: rtl/mem_rd_skid.sv
// rtl/mem_rd_skid.sv - 2-entry fall-through FIFO absorbing the registered memory read latency
module mem_rd_skid
    import mem_rd_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic             head_valid,
    output logic [WIDTH-1:0] head_data,
    output logic [1:0]       count
);

    logic [WIDTH-1:0] e0;
    logic [WIDTH-1:0] e1;
    logic [1:0]       cnt;
    logic             empty;
    logic             pop_s;
    logic             push_s;

    assign empty = (cnt == 2'd0);
    assign count = cnt;

    // An arriving word is visible in the same cycle when nothing is stored ahead of it;
    // with no word present the head reads as zero rather than stale memory output.
    assign head_valid = !empty || push;
    assign head_data  = !empty ? e0 : (push ? push_data : '0);

    // A word that arrives and leaves in the same cycle while empty is never stored.
    assign pop_s  = pop && !empty;
    assign push_s = push && !(pop && empty) && ((cnt != 2'(SKID_DEPTH)) || pop_s);

    // Entry shift register: e0 is always the head, e1 the word behind it.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= 2'd0;
            e0  <= '0;
            e1  <= '0;
        end else begin
            case ({push_s, pop_s})
                2'b11: begin
                    if (cnt == 2'd1) begin
                        e0 <= push_data;
                    end else begin
                        e0 <= e1;
                        e1 <= push_data;
                    end
                end
                2'b01: begin
                    e0  <= e1;
                    cnt <= cnt - 2'd1;
                end
                2'b10: begin
                    if (cnt == 2'd0) begin
                        e0 <= push_data;
                    end else begin
                        e1 <= push_data;
                    end
                    cnt <= cnt + 2'd1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/mem_rd_stream.sv
// rtl/mem_rd_stream.sv - streams a wrapping address range out of a memory read port (MEM_RD_STREAM_LAST_EN adds m_last)
module mem_rd_stream
    import mem_rd_pkg::*;
#(
    parameter  int WIDTH = 32,
    parameter  int DEPTH = 512,
    localparam int AW    = $clog2(DEPTH),
    localparam int LW    = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [AW-1:0] base_addr,
    input  logic [LW-1:0] len,
    output logic          busy,
    output logic          done,
    mem_rd_stream_if.master bus
);

    state_t           state;
    logic [AW-1:0]    addr_q;
    logic [LW-1:0]    issue_left;
    logic [LW-1:0]    beat_left;
    logic             inflight;
    logic [1:0]       skid_count;
    logic             head_valid;
    logic [WIDTH-1:0] head_data;
    logic             pop;
    logic             issue;
    logic [2:0]       committed;
    logic [AW-1:0]    addr_next;

    assign pop = head_valid && bus.m_ready;

    // Words already owned by the skid (stored or arriving) minus the one leaving now;
    // a new read may only go out if its data is certain to find a free slot.
    assign committed = {1'b0, skid_count} + {2'b0, inflight};
    assign issue     = (state == RUN) && (committed <= (3'd1 + {2'b0, pop}));

    assign addr_next = (addr_q == AW'(DEPTH - 1)) ? '0 : addr_q + AW'(1);

    assign bus.rd_en   = issue;
    assign bus.rd_addr = addr_q;
    assign bus.m_valid = head_valid;
    assign bus.m_data  = head_data;
`ifdef MEM_RD_STREAM_LAST_EN
    assign bus.m_last  = head_valid && (beat_left == LW'(1));
`endif

    // Tracks the read whose data lands on rd_data next cycle; cleared by reset so it is dropped.
    always_ff @(posedge clk) begin
        if (rst) begin
            inflight <= 1'b0;
        end else begin
            inflight <= issue;
        end
    end

    // Control FSM with address, issue and beat counters and registered busy/done.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            addr_q     <= '0;
            issue_left <= '0;
            beat_left  <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        addr_q     <= base_addr;
                        issue_left <= len;
                        beat_left  <= len;
                        busy       <= 1'b1;
                        if (len == '0) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end else begin
                            state <= RUN;
                        end
                    end
                end
                RUN: begin
                    if (issue) begin
                        addr_q     <= addr_next;
                        issue_left <= issue_left - LW'(1);
                        if (issue_left == LW'(1)) begin
                            state <= DRAIN;
                        end
                    end
                    if (pop) begin
                        beat_left <= beat_left - LW'(1);
                    end
                end
                DRAIN: begin
                    if (pop) begin
                        beat_left <= beat_left - LW'(1);
                        if (beat_left == LW'(1)) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    mem_rd_skid #(
        .WIDTH(WIDTH)
    ) u_skid (
        .clk       (clk),
        .rst       (rst),
        .push      (inflight),
        .push_data (bus.rd_data),
        .pop       (pop),
        .head_valid(head_valid),
        .head_data (head_data),
        .count     (skid_count)
    );

endmodule
